// File: rtl/uart_rx_mem_loader.sv
// uart_rx_mem_loader: oversampled UART receiver that writes each good character
// to the next sequential memory address, pulsing frame_done on the DEPTH-th write.
module uart_rx_mem_loader #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int ADDR_W     = 10,
  parameter int DEPTH      = 784
)(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  input  logic                 clear,
  output logic                 mem_we,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_BITS-1:0] mem_din,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 parity_err,
  output logic                 framing_err,
  output logic                 frame_done,
  output logic                 busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [ADDR_W-1:0] A_LAST = ADDR_W'(DEPTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  state_t state_q, state_d;
  logic rx_m_q, rx_s_q;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d, rx_data_q, rx_data_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic pbit_q, pbit_d, ferr_q, ferr_d, arm_q, arm_d;
  logic perr_q, perr_d, fout_q, fout_d, valid_q, valid_d, we_q, we_d;
  logic done, t_end, ferr_now, perr_now;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_m_q    <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= IDLE;
      tcnt_q    <= '0;
      bcnt_q    <= '0;
      shift_q   <= '0;
      rx_data_q <= '0;
      waddr_q   <= '0;
      pbit_q    <= 1'b0;
      ferr_q    <= 1'b0;
      arm_q     <= 1'b0;
      perr_q    <= 1'b0;
      fout_q    <= 1'b0;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
    end else begin
      rx_m_q    <= rx;
      rx_s_q    <= rx_m_q;
      state_q   <= state_d;
      tcnt_q    <= tcnt_d;
      bcnt_q    <= bcnt_d;
      shift_q   <= shift_d;
      rx_data_q <= rx_data_d;
      waddr_q   <= waddr_d;
      pbit_q    <= pbit_d;
      ferr_q    <= ferr_d;
      arm_q     <= arm_d;
      perr_q    <= perr_d;
      fout_q    <= fout_d;
      valid_q   <= valid_d;
      we_q      <= we_d;
    end
  end
  always_comb begin
    state_d  = state_q;
    tcnt_d   = tcnt_q;
    bcnt_d   = bcnt_q;
    shift_d  = shift_q;
    pbit_d   = pbit_q;
    ferr_d   = ferr_q;
    arm_d    = arm_q;
    done     = 1'b0;
    t_end    = tcnt_q == T_END;
    ferr_now = ferr_q | ~rx_s_q;
    perr_now = (PARITY != 0) && ((^shift_q ^ pbit_q) != (PARITY == 2));
    if (tick) begin
      case (state_q)
        // arm_q blocks a new start until the line has been seen high (break recovery)
        IDLE: begin
          if (rx_s_q) arm_d = 1'b1;
          else if (arm_q) begin
            state_d = START;
            tcnt_d  = '0;
          end
        end
        START: begin
          if (tcnt_q == T_MID) begin
            state_d = rx_s_q ? IDLE : DATA;
            tcnt_d  = '0;
            bcnt_d  = '0;
            ferr_d  = 1'b0;
          end else tcnt_d = tcnt_q + TW'(1);
        end
        DATA: begin
          if (t_end) begin
            tcnt_d  = '0;
            shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
            bcnt_d  = bcnt_q + 4'd1;
            if (bcnt_q == 4'(DATA_BITS - 1)) begin
              bcnt_d  = '0;
              state_d = (PARITY != 0) ? PAR : STOP;
            end
          end else tcnt_d = tcnt_q + TW'(1);
        end
        PAR: begin
          if (t_end) begin
            tcnt_d  = '0;
            pbit_d  = rx_s_q;
            state_d = STOP;
          end else tcnt_d = tcnt_q + TW'(1);
        end
        STOP: begin
          if (t_end) begin
            tcnt_d = '0;
            bcnt_d = bcnt_q + 4'd1;
            ferr_d = ferr_now;
            if (bcnt_q == 4'(STOP_BITS - 1)) begin
              bcnt_d  = '0;
              state_d = IDLE;
              arm_d   = rx_s_q;
              done    = 1'b1;
            end
          end else tcnt_d = tcnt_q + TW'(1);
        end
        default: state_d = IDLE;
      endcase
    end
    valid_d   = done;
    we_d      = done & ~perr_now & ~ferr_now;
    rx_data_d = done ? shift_q : rx_data_q;
    perr_d    = done ? perr_now : perr_q;
    fout_d    = done ? ferr_now : fout_q;
    waddr_d   = clear ? '0 : !we_q ? waddr_q : (waddr_q == A_LAST) ? '0 : waddr_q + ADDR_W'(1);
  end
  assign mem_we      = we_q;
  assign mem_addr    = waddr_q;
  assign mem_din     = rx_data_q;
  assign rx_valid    = valid_q;
  assign rx_data     = rx_data_q;
  assign parity_err  = perr_q;
  assign framing_err = fout_q;
  assign frame_done  = we_q && (waddr_q == A_LAST);
  assign busy        = state_q != IDLE;
endmodule
